// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port and a
// per-register pending scoreboard. Define REGFILE_BYPASS_EN for write-first reads.
module regfile_sb #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A,
    input  logic [ADDR_W-1:0] B,
    output logic [DATA_W-1:0] QA,
    output logic [DATA_W-1:0] QB,
    input  logic [ADDR_W-1:0] W,
    input  logic [DATA_W-1:0] DATA,
    input  logic              Write,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RSV_ADDR,
    output logic              PA,
    output logic              PB,
    output logic              STALL,
    output logic [ADDR_W:0]   PEND_CNT,
    output logic              RSV_ERR
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             pend, pend_nxt;
    logic [ADDR_W:0]              cnt, cnt_nxt;
    logic                         err, err_nxt;
    logic                         wr_en, rsv_en, set_inc, clr_dec;

    // Register 0 is inert when hard-wired to zero: writes and reserves drop.
    assign wr_en  = Write && !((ZERO_R0 != 0) && (W == '0));
    assign rsv_en = RSV && !((ZERO_R0 != 0) && (RSV_ADDR == '0));

    // Only one set and one clear per cycle, so the count moves by at most one.
    assign set_inc = rsv_en && !pend[RSV_ADDR];
    assign clr_dec = wr_en && pend[W] && !(rsv_en && (RSV_ADDR == W));
    assign err_nxt = rsv_en && pend[RSV_ADDR] && !(wr_en && (W == RSV_ADDR));

    always_comb begin
        pend_nxt = pend;
        if (wr_en)  pend_nxt[W]        = 1'b0;
        if (rsv_en) pend_nxt[RSV_ADDR] = 1'b1;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (set_inc && !clr_dec)      cnt_nxt = cnt + 1'b1;
        else if (clr_dec && !set_inc) cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem  <= '0;
            pend <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (wr_en) mem[W] <= DATA;
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
            err  <= err_nxt;
        end
    end

    logic [1:0][ADDR_W-1:0] raddr;
    logic [1:0][DATA_W-1:0] rdata;
    logic [1:0]             rpend;

    assign raddr = {B, A};

    always_comb begin
        rdata = '0;
        rpend = '0;
        for (int p = 0; p < 2; p++) begin
            rdata[p] = mem[raddr[p]];
            rpend[p] = pend[raddr[p]];
`ifdef REGFILE_BYPASS_EN
            // Gated by RST so the ports stay at zero while reset is held.
            if (RST && wr_en && (W == raddr[p])) begin
                rdata[p] = DATA;
                rpend[p] = rsv_en && (RSV_ADDR == raddr[p]);
            end
`endif
            if ((ZERO_R0 != 0) && (raddr[p] == '0)) begin
                rdata[p] = '0;
                rpend[p] = 1'b0;
            end
        end
    end

    assign QA       = rdata[0];
    assign QB       = rdata[1];
    assign PA       = rpend[0];
    assign PB       = rpend[1];
    assign STALL    = rpend[0] | rpend[1];
    assign PEND_CNT = cnt;
    assign RSV_ERR  = err;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one default instance plus one with ZERO_R0=1.
module tb_regfile_sb;
    logic       clk, rst_n;
    logic [3:0] a, b, w, rsv_addr;
    logic [7:0] data;
    logic       wr, rsv;

    logic [7:0] qa, qb, z_qa, z_qb;
    logic       pa, pb, stall, err, z_pa, z_pb, z_stall, z_err;
    logic [4:0] cnt, z_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    regfile_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_R0(0)) dut (
        .CLK(clk), .RST(rst_n), .A(a), .B(b), .QA(qa), .QB(qb),
        .W(w), .DATA(data), .Write(wr), .RSV(rsv), .RSV_ADDR(rsv_addr),
        .PA(pa), .PB(pb), .STALL(stall), .PEND_CNT(cnt), .RSV_ERR(err)
    );

    regfile_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_R0(1)) dut_z (
        .CLK(clk), .RST(rst_n), .A(a), .B(b), .QA(z_qa), .QB(z_qb),
        .W(w), .DATA(data), .Write(wr), .RSV(rsv), .RSV_ADDR(rsv_addr),
        .PA(z_pa), .PB(z_pb), .STALL(z_stall), .PEND_CNT(z_cnt), .RSV_ERR(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1-2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; rsv = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = 4'd3; b = 4'd0; w = 4'd0; rsv_addr = 4'd0; data = 8'h00;
        idle();
        #2;
        chk_cnt++; if ({qa, qb, pa, pb, stall, cnt, err} !== 31'd0)
            $display("FAIL reset_outputs: got qa=%h qb=%h pa=%b pb=%b stall=%b cnt=%0d err=%b, want all 0",
                     qa, qb, pa, pb, stall, cnt, err); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        wr = 1'b1; w = 4'd3; data = 8'h5A;
        tick();
        idle(); rsv = 1'b1; rsv_addr = 4'd4;
        #1;
        chk_cnt++; if (qa !== 8'h5A) $display("FAIL reset_prewrite: qa=%h want 5a", qa); else pass_cnt++;
        tick();
        idle();
        #1;
        chk_cnt++; if (cnt !== 5'd1) $display("FAIL reset_precnt: cnt=%0d want 1", cnt); else pass_cnt++;
        #1; rst_n = 1'b0; #1;
        chk_cnt++; if (qa !== 8'h00 || cnt !== 5'd0)
            $display("FAIL reset_async: qa=%h cnt=%0d want 00/0", qa, cnt); else pass_cnt++;
        // Traffic presented while reset is held must be discarded.
        wr = 1'b1; w = 4'd3; data = 8'h77; rsv = 1'b1; rsv_addr = 4'd6;
        #1;
        chk_cnt++; if (qa !== 8'h00 || pa !== 1'b0) $display("FAIL reset_hold_read: qa=%h pa=%b want 00/0", qa, pa); else pass_cnt++;
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (qa !== 8'h00 || cnt !== 5'd0)
            $display("FAIL reset_inflight: qa=%h cnt=%0d want 00/0", qa, cnt); else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [7:0] exp_q;
        a = 4'd5; b = 4'd5;
        wr = 1'b1; w = 4'd5; data = 8'hC3;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_q = 8'hC3;
`else
        exp_q = 8'h00;
`endif
        chk_cnt++; if (qa !== exp_q) $display("FAIL wr_same_cycle: qa=%h want %h", qa, exp_q); else pass_cnt++;
        tick();
        idle();
        #1;
        chk_cnt++; if (qa !== 8'hC3 || qb !== 8'hC3)
            $display("FAIL wr_readback: qa=%h qb=%h want c3/c3", qa, qb); else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        a = 4'd7; b = 4'd5;
        rsv = 1'b1; rsv_addr = 4'd7;
        tick();
        idle();
        #1;
        chk_cnt++; if (pa !== 1'b1 || pb !== 1'b0 || stall !== 1'b1 || cnt !== 5'd1)
            $display("FAIL sb_reserve: pa=%b pb=%b stall=%b cnt=%0d want 1/0/1/1", pa, pb, stall, cnt); else pass_cnt++;
        wr = 1'b1; w = 4'd7; data = 8'h11;
        tick();
        idle();
        #1;
        chk_cnt++; if (pa !== 1'b0 || stall !== 1'b0 || cnt !== 5'd0 || qa !== 8'h11)
            $display("FAIL sb_release: pa=%b stall=%b cnt=%0d qa=%h want 0/0/0/11", pa, stall, cnt, qa); else pass_cnt++;
    endtask

    task automatic test_collision();
        a = 4'd2; b = 4'd0;
        rsv = 1'b1; rsv_addr = 4'd2; wr = 1'b1; w = 4'd2; data = 8'h44;
        tick();
        idle();
        #1;
        chk_cnt++; if (qa !== 8'h44 || pa !== 1'b1 || cnt !== 5'd1 || err !== 1'b0)
            $display("FAIL col_first: qa=%h pa=%b cnt=%0d err=%b want 44/1/1/0", qa, pa, cnt, err); else pass_cnt++;
        rsv = 1'b1; rsv_addr = 4'd2;
        tick();
        idle();
        #1;
        chk_cnt++; if (err !== 1'b1 || cnt !== 5'd1)
            $display("FAIL col_err: err=%b cnt=%0d want 1/1", err, cnt); else pass_cnt++;
        tick();
        chk_cnt++; if (err !== 1'b0) $display("FAIL col_err_pulse: err=%b want 0", err); else pass_cnt++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            rsv = 1'b1; rsv_addr = 4'(i);
            tick();
        end
        idle();
        a = 4'd0; b = 4'd15;
        #1;
        chk_cnt++; if (cnt !== 5'd16 || stall !== 1'b1)
            $display("FAIL full_cnt: cnt=%0d stall=%b want 16/1", cnt, stall); else pass_cnt++;
        rsv = 1'b1; rsv_addr = 4'd5;
        tick();
        idle();
        #1;
        chk_cnt++; if (cnt !== 5'd16 || err !== 1'b1)
            $display("FAIL full_nowrap: cnt=%0d err=%b want 16/1", cnt, err); else pass_cnt++;
        rsv = 1'b1; rsv_addr = 4'd5; wr = 1'b1; w = 4'd9; data = 8'h99;
        tick();
        idle();
        a = 4'd9; b = 4'd5;
        #1;
        chk_cnt++; if (cnt !== 5'd15 || err !== 1'b1 || pa !== 1'b0 || pb !== 1'b1 || qa !== 8'h99)
            $display("FAIL full_mixed: cnt=%0d err=%b pa=%b pb=%b qa=%h want 15/1/0/1/99",
                     cnt, err, pa, pb, qa); else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        #1; rst_n = 1'b0; #2; rst_n = 1'b1;
        tick();
        a = 4'd0; b = 4'd0;
        wr = 1'b1; w = 4'd0; data = 8'hFF; rsv = 1'b1; rsv_addr = 4'd0;
        #1;
        chk_cnt++; if (z_qa !== 8'h00 || z_pa !== 1'b0)
            $display("FAIL zero_same_cycle: qa=%h pa=%b want 00/0", z_qa, z_pa); else pass_cnt++;
        tick();
        rsv = 1'b1; rsv_addr = 4'd0; wr = 1'b0;
        #1;
        chk_cnt++; if (z_qa !== 8'h00 || z_pa !== 1'b0 || z_stall !== 1'b0 || z_cnt !== 5'd0 || z_err !== 1'b0)
            $display("FAIL zero_after: qa=%h pa=%b stall=%b cnt=%0d err=%b want 00/0/0/0/0",
                     z_qa, z_pa, z_stall, z_cnt, z_err); else pass_cnt++;
        chk_cnt++; if (qa !== 8'hFF || pa !== 1'b1 || cnt !== 5'd1)
            $display("FAIL zero_plain_r0: qa=%h pa=%b cnt=%0d want ff/1/1", qa, pa, cnt); else pass_cnt++;
        tick();
        idle();
        #1;
        chk_cnt++; if (z_err !== 1'b0 || z_cnt !== 5'd0 || err !== 1'b1)
            $display("FAIL zero_reserve_again: z_err=%b z_cnt=%0d err=%b want 0/0/1", z_err, z_cnt, err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_full();
        test_zero_reg();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
